// File: rtl/oflow_core_pe_result_arbiter_if.sv
// PE result collection and result-memory write bundle.
// The arbiter takes the master side, the PE array and memory the slave side.
interface oflow_core_pe_result_arbiter_if #(
  parameter int PE_NUM = 24,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [PE_NUM-1:0]        result_valid_i;
  logic [PE_NUM*DATA_W-1:0] result_data_i;
  logic [PE_NUM-1:0]        result_ack_i;
  logic                     wr_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;

  modport master (
    input  result_valid_i,
    input  result_data_i,
    input  wr_ready,
    output result_ack_i,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output result_valid_i,
    output result_data_i,
    output wr_ready,
    input  result_ack_i,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/oflow_core_pe_result_arbiter.sv
// Round-robin drain of per-PE results into one result-memory write port.
// Each active PE is written once per set at base_addr + PE index.
module oflow_core_pe_result_arbiter #(
  parameter int PE_NUM = 24,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 5
) (
  input  logic                clk,
  input  logic                reset_N,
  input  logic                start_set,
  input  logic [PE_NUM-1:0]   active_mask,
  input  logic [ADDR_W-1:0]   base_addr,
  oflow_core_pe_result_arbiter_if.master rif,
  output logic                busy,
  output logic                drain_done,
  output logic [IDX_W:0]      served_cnt,
  output logic                err_overrun
);

  typedef enum logic [1:0] {
    idle_st,
    drain_st,
    done_st
  } state_t;

  state_t              state;
  logic [PE_NUM-1:0]   mask_q;
  logic [PE_NUM-1:0]   served;
  logic [ADDR_W-1:0]   base_q;
  logic [IDX_W-1:0]    rr_ptr;

  logic [PE_NUM-1:0]   pending;
  logic [PE_NUM-1:0]   eligible;
  logic [PE_NUM-1:0]   gnt_oh;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    cand;
  logic                gnt_v;
  logic                last_gnt;
  logic [IDX_W-1:0]    rr_next;

  assign pending  = mask_q & ~served;
  assign eligible = pending & rif.result_valid_i;

  // First eligible PE at or above rr_ptr, wrapping past PE_NUM-1.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state == drain_st && rif.wr_ready) begin
      for (int i = 0; i < PE_NUM; i++) begin
        if (int'(rr_ptr) + i >= PE_NUM)
          cand = IDX_W'(int'(rr_ptr) + i - PE_NUM);
        else
          cand = IDX_W'(int'(rr_ptr) + i);
        if (!gnt_v && eligible[cand]) begin
          gnt_v   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt_oh   = gnt_v ? (PE_NUM'(1) << gnt_idx) : '0;
  assign last_gnt = gnt_v && ((pending & ~gnt_oh) == '0);
  assign rr_next  = (gnt_idx == IDX_W'(PE_NUM-1)) ? '0
                  : gnt_idx + IDX_W'(1);

  assign rif.result_ack_i = gnt_oh;
  assign err_overrun      = start_set & busy;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state       <= idle_st;
      mask_q      <= '0;
      served      <= '0;
      base_q      <= '0;
      rr_ptr      <= '0;
      served_cnt  <= '0;
      busy        <= 1'b0;
      drain_done  <= 1'b0;
      rif.wr_en   <= 1'b0;
      rif.wr_addr <= '0;
      rif.wr_data <= '0;
    end else begin
      rif.wr_en  <= 1'b0;
      drain_done <= 1'b0;
      unique case (state)
        idle_st: begin
          if (start_set) begin
            mask_q     <= active_mask;
            base_q     <= base_addr;
            served     <= '0;
            served_cnt <= '0;
            rr_ptr     <= '0;
            busy       <= 1'b1;
            if (active_mask == '0) begin
              state      <= done_st;
              drain_done <= 1'b1;
            end else begin
              state <= drain_st;
            end
          end
        end
        drain_st: begin
          if (gnt_v) begin
            served      <= served | gnt_oh;
            served_cnt  <= served_cnt + (IDX_W+1)'(1);
            rr_ptr      <= rr_next;
            rif.wr_en   <= 1'b1;
            rif.wr_addr <= base_q + ADDR_W'(gnt_idx);
            rif.wr_data <= rif.result_data_i[gnt_idx*DATA_W +: DATA_W];
            if (last_gnt) begin
              state      <= done_st;
              drain_done <= 1'b1;
            end
          end
        end
        done_st: begin
          state <= idle_st;
          busy  <= 1'b0;
        end
        default: state <= idle_st;
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_core_pe_result_arbiter.sv
// Scoreboard bench for the PE result arbiter.
// Stimulus queues expected acks, writes and set completions; a monitor checks them.
module tb_oflow_core_pe_result_arbiter;
  localparam int PE_NUM = 24;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int IDX_W  = 5;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int served;
    int rel;
  } done_t;

  logic              clk = 1'b0;
  logic              reset_N = 1'b0;
  logic              start_set = 1'b0;
  logic [PE_NUM-1:0] active_mask = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              drain_done;
  logic [IDX_W:0]    served_cnt;
  logic              err_overrun;

  oflow_core_pe_result_arbiter_if #(
    .PE_NUM(PE_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) ifc ();

  oflow_core_pe_result_arbiter #(
    .PE_NUM(PE_NUM), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) dut (
    .clk         (clk),
    .reset_N     (reset_N),
    .start_set   (start_set),
    .active_mask (active_mask),
    .base_addr   (base_addr),
    .rif         (ifc),
    .busy        (busy),
    .drain_done  (drain_done),
    .served_cnt  (served_cnt),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int    exp_ack[$];
  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    done_cnt = 0;
  logic  real_start = 1'b0;
  logic  exp_err = 1'b0;
  logic  final_req = 1'b0;
  logic [PE_NUM-1:0] acked;
  logic [7:0]        tag = '0;
  logic [ADDR_W-1:0] cur_base = '0;

  function automatic logic [DATA_W-1:0] pe_data(input logic [7:0] t,
                                                 input int k);
    return {t, 8'(k*29+7), 8'hA5, 8'(k)};
  endfunction

  task automatic prep(input logic [7:0] t, input logic [ADDR_W-1:0] b);
    tag = t;
    cur_base = b;
    for (int k = 0; k < PE_NUM; k++)
      ifc.result_data_i[k*DATA_W +: DATA_W] = pe_data(t, k);
  endtask

  task automatic push_ack(input int k);
    exp_ack.push_back(k);
  endtask

  task automatic push_wr(input int k);
    wr_t w;
    w.addr = cur_base + ADDR_W'(k);
    w.data = pe_data(tag, k);
    exp_wr.push_back(w);
  endtask

  task automatic push_both(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      push_ack(k);
      push_wr(k);
    end
  endtask

  // PE model: a PE drops valid the cycle after it sees its ack.
  task automatic step();
    @(negedge clk);
    acked = ifc.result_ack_i;
    @(posedge clk);
    #1;
    ifc.result_valid_i = ifc.result_valid_i & ~acked;
    start_set  = 1'b0;
    real_start = 1'b0;
    exp_err    = 1'b0;
  endtask

  task automatic run_set(input logic [PE_NUM-1:0] m,
                         input logic [ADDR_W-1:0] b,
                         input logic [PE_NUM-1:0] v,
                         input int served, input int rel,
                         input int st_lo, input int st_hi,
                         input logic [PE_NUM-1:0] late_m,
                         input int late_c, input int ovr_c);
    int    d0;
    done_t d;
    d0 = done_cnt;
    d.served = served;
    d.rel = rel;
    exp_done.push_back(d);
    active_mask = m;
    base_addr = b;
    ifc.result_valid_i = v;
    start_set = 1'b1;
    real_start = 1'b1;
    for (int c = 0; c <= rel + 6; c++) begin
      ifc.wr_ready = !(c >= st_lo && c <= st_hi);
      if (c == late_c)
        ifc.result_valid_i = ifc.result_valid_i | late_m;
      if (c == ovr_c) begin
        start_set = 1'b1;
        exp_err = 1'b1;
        active_mask = 24'h000001;
        base_addr = 10'h2AA;
      end
      step();
      if (done_cnt != d0) break;
    end
    ifc.wr_ready = 1'b1;
    ifc.result_valid_i = '0;
    step();
  endtask

  initial begin : monitor
    logic [PE_NUM-1:0] oh;
    wr_t   w;
    done_t d;
    int    e;
    forever begin
      @(negedge clk);
      cyc++;
      if (real_start) start_cyc = cyc;
      if (!reset_N) begin
        checks++;
        if (busy || drain_done || err_overrun || ifc.wr_en ||
            served_cnt != 0 || ifc.result_ack_i != 0 ||
            ifc.wr_addr != 0 || ifc.wr_data != 0) begin
          failures++;
          $display("FAIL reset_outputs got busy=%b done=%b err=%b wr_en=%b cnt=%0d ack=%h addr=%h data=%h required all 0",
                   busy, drain_done, err_overrun, ifc.wr_en, served_cnt,
                   ifc.result_ack_i, ifc.wr_addr, ifc.wr_data);
        end
        checks++;
        if (exp_ack.size() != 0 || exp_wr.size() != 0) begin
          failures++;
          $display("FAIL reset_pending got acks_left=%0d wr_left=%0d required 0",
                   exp_ack.size(), exp_wr.size());
        end
      end else begin
        if (ifc.result_ack_i != 0) begin
          checks++;
          if (exp_ack.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack got=%h required none",
                     ifc.result_ack_i);
          end else begin
            e = exp_ack.pop_front();
            oh = PE_NUM'(1) << e;
            if (ifc.result_ack_i != oh) begin
              failures++;
              $display("FAIL ack_order got=%h required=%h",
                       ifc.result_ack_i, oh);
            end
          end
        end
        if (ifc.wr_en) begin
          checks++;
          if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write got addr=%h data=%h required none",
                     ifc.wr_addr, ifc.wr_data);
          end else begin
            w = exp_wr.pop_front();
            if (ifc.wr_addr != w.addr || ifc.wr_data != w.data) begin
              failures++;
              $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                       ifc.wr_addr, ifc.wr_data, w.addr, w.data);
            end
          end
        end
        if (drain_done) begin
          done_cnt++;
          checks++;
          if (exp_done.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done got drain_done=1 required 0");
          end else begin
            d = exp_done.pop_front();
            if (int'(served_cnt) != d.served || cyc - start_cyc != d.rel) begin
              failures++;
              $display("FAIL done got cnt=%0d cycle=%0d required cnt=%0d cycle=%0d",
                       served_cnt, cyc - start_cyc, d.served, d.rel);
            end
          end
          checks++;
          if (exp_ack.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL done_incomplete got acks_left=%0d wr_left=%0d required 0",
                     exp_ack.size(), exp_wr.size());
          end
        end else if (exp_done.size() != 0 &&
                     cyc - start_cyc > exp_done[0].rel + 3) begin
          checks++;
          failures++;
          $display("FAIL done_timeout got no drain_done by cycle %0d required cycle %0d",
                   cyc - start_cyc, exp_done[0].rel);
          d = exp_done.pop_front();
        end
        if (err_overrun || exp_err) begin
          checks++;
          if (err_overrun != exp_err) begin
            failures++;
            $display("FAIL err_overrun got=%b required=%b",
                     err_overrun, exp_err);
          end
        end
      end
      if (final_req) begin
        checks++;
        if (exp_ack.size() != 0 || exp_wr.size() != 0 ||
            exp_done.size() != 0) begin
          failures++;
          $display("FAIL leftover got acks=%0d writes=%0d dones=%0d required 0",
                   exp_ack.size(), exp_wr.size(), exp_done.size());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish required finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.result_valid_i = '0;
    ifc.wr_ready = 1'b1;
    prep(8'h00, '0);
    repeat (3) @(posedge clk);
    #1;
    reset_N = 1'b1;
    @(posedge clk);
    #1;

    // full set with an overrun pulse mid-drain
    prep(8'h11, 10'h100);
    push_both(0, 23);
    run_set(24'hFFFFFF, 10'h100, 24'hFFFFFF, 24, 25,
            -1, -1, '0, -1, 10);

    // partial last set, all PEs valid
    prep(8'h22, 10'h100);
    push_both(0, 4);
    run_set(24'h00001F, 10'h100, 24'hFFFFFF, 5, 6,
            -1, -1, '0, -1, -1);

    // late valids force a wrap back to PE0
    prep(8'h33, 10'h040);
    push_both(2, 3);
    push_both(0, 1);
    run_set(24'h00000F, 10'h040, 24'h00000C, 4, 5,
            -1, -1, 24'h000003, 3, -1);

    // write backpressure for cycles 3..6
    prep(8'h44, 10'h200);
    push_both(0, 23);
    run_set(24'hFFFFFF, 10'h200, 24'hFFFFFF, 24, 29,
            3, 6, '0, -1, -1);

    // empty mask
    prep(8'h55, 10'h123);
    run_set(24'h000000, 10'h123, 24'hFFFFFF, 0, 1,
            -1, -1, '0, -1, -1);

    // reset after seven writes
    prep(8'h66, 10'h100);
    for (int k = 0; k <= 7; k++) push_ack(k);
    for (int k = 0; k <= 6; k++) push_wr(k);
    active_mask = 24'hFFFFFF;
    base_addr = 10'h100;
    ifc.result_valid_i = 24'hFFFFFF;
    start_set = 1'b1;
    real_start = 1'b1;
    for (int c = 0; c <= 7; c++) step();
    @(negedge clk);
    #1;
    reset_N = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_N = 1'b1;
    ifc.result_valid_i = '0;
    @(posedge clk);
    #1;

    // fresh set after reset, address wraps past 0x3FF
    prep(8'h77, 10'h3FE);
    push_both(0, 3);
    run_set(24'h00000F, 10'h3FE, 24'hFFFFFF, 4, 5,
            -1, -1, '0, -1, -1);

    final_req = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
